// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the frame buffer and the colour DAC stage
package fb_pkg;
    typedef enum logic {FB_CLEAR, FB_RUN} fb_state_e;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    function automatic int fb_clog2(input int v);
        int r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction
    function automatic int color_bits(input int rd, input int gd, input int bd);
        return rd + gd + bd;
    endfunction
    function automatic logic [23:0] rgb_pack(input rgb_t c, input int gd, input int bd);
        return 24'((int'(c.r) << (gd + bd)) | (int'(c.g) << bd) | int'(c.b));
    endfunction
    function automatic rgb_t rgb_unpack(input logic [23:0] w, input int rd, input int gd, input int bd);
        rgb_t c;
        c.b = 8'(w & ~(24'hFFFFFF << bd));
        c.g = 8'((w >> bd) & ~(24'hFFFFFF << gd));
        c.r = 8'((w >> (gd + bd)) & ~(24'hFFFFFF << rd));
        return c;
    endfunction
endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port RAM, one write port and one registered read-before-write read port
module fb_dpram #(
    parameter int DW = 6,
    parameter int AW = 17,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d, rdata_q;
    always_comb rdata_d = rclr ? '0 : re ? mem[raddr] : rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/frame_buffer_dp.sv
// frame_buffer_dp: paged RGB frame buffer with handshaked write port and scaled raster scanout
module frame_buffer_dp
    import fb_pkg::*;
#(
    parameter int H_WIDTH = 200,
    parameter int V_WIDTH = 600,
    parameter int R_DEPTH = 2,
    parameter int G_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int H_SCALE = 4,
    parameter int V_SCALE = 1,
    parameter int PAGES = 1,
    parameter int CLEAR_COLOR = 0,
    localparam int COLOR_BITS = color_bits(R_DEPTH, G_DEPTH, B_DEPTH),
    localparam int AW = fb_clog2(H_WIDTH * V_WIDTH * PAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic                  pix_en,
    output logic [COLOR_BITS-1:0] color_out,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [COLOR_BITS-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  init_done
);
    localparam int NPIX = H_WIDTH * V_WIDTH;
    localparam int NTOT = NPIX * PAGES;
    localparam int AW1 = AW + 1;
    localparam int BW = fb_clog2(NPIX + 1);
    localparam int HW = fb_clog2(H_WIDTH + 1);
    localparam int HSW = fb_clog2(H_SCALE + 1);
    localparam int VSW = fb_clog2(V_SCALE + 1);
    localparam logic [AW-1:0] PAGE_OFF = AW'(NPIX);
    fb_state_e state_d, state_q;
    logic [AW-1:0] clr_addr_d, clr_addr_q, rd_addr, waddr;
    logic front_d, front_q, pend_d, pend_q;
    logic [BW-1:0] base_d, base_q;
    logic [HW-1:0] h_d, h_q, h_e;
    logic [HSW-1:0] hsub_d, hsub_q, hsub_e;
    logic [VSW-1:0] vsub_d, vsub_q;
    logic [COLOR_BITS-1:0] wdata;
    logic ls, swap, vwrap, adv, hwrap, last, rd_en, we, rclr;
    always_comb begin
        ls = line_start && !frame_start;
        swap = PAGES == 2 && frame_start && (pend_q || swap_req);
        front_d = front_q ^ swap;
        pend_d = PAGES == 2 && !swap && (pend_q || swap_req);
        vwrap = vsub_q == VSW'(V_SCALE - 1);
        base_d = frame_start ? '0 : ls && vwrap && base_q < BW'(NPIX) ? base_q + BW'(H_WIDTH) : base_q;
        vsub_d = frame_start ? '0 : !ls ? vsub_q : vwrap ? '0 : vsub_q + 1'b1;
        h_e = frame_start || line_start ? '0 : h_q;
        hsub_e = frame_start || line_start ? '0 : hsub_q;
        adv = pix_en && h_e < HW'(H_WIDTH);
        hwrap = hsub_e == HSW'(H_SCALE - 1);
        hsub_d = adv ? (hwrap ? '0 : hsub_e + 1'b1) : hsub_e;
        h_d = adv && hwrap ? h_e + 1'b1 : h_e;
        rd_en = state_q == FB_RUN && adv && base_d < BW'(NPIX);
        rd_addr = (front_d ? PAGE_OFF : '0) + AW'(base_d) + AW'(h_e);
        last = clr_addr_q == AW'(NTOT - 1);
        state_d = state_q == FB_CLEAR && last ? FB_RUN : state_q;
        clr_addr_d = state_q == FB_CLEAR ? clr_addr_q + 1'b1 : '0;
        waddr = state_q == FB_CLEAR ? clr_addr_q : ((PAGES == 2 && !front_q) ? PAGE_OFF : '0) + wr_addr;
        wdata = state_q == FB_CLEAR ? COLOR_BITS'(CLEAR_COLOR) : wr_data;
        we = rst_n && (state_q == FB_CLEAR || (wr_valid && {1'b0, wr_addr} < AW1'(NPIX)));
        rclr = !rst_n || state_q == FB_CLEAR;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FB_CLEAR;
            clr_addr_q <= '0;
            front_q <= 1'b0;
            pend_q <= 1'b0;
            base_q <= '0;
            h_q <= '0;
            hsub_q <= '0;
            vsub_q <= '0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
            front_q <= front_d;
            pend_q <= pend_d;
            base_q <= base_d;
            h_q <= h_d;
            hsub_q <= hsub_d;
            vsub_q <= vsub_d;
        end
    end
    assign init_done = state_q == FB_RUN;
    assign wr_ready = state_q == FB_RUN;
    assign swap_done = rst_n && swap;
    fb_dpram #(.DW(COLOR_BITS), .AW(AW), .DEPTH(NTOT)) u_ram (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .re(rd_en),
        .rclr(rclr),
        .raddr(rd_addr),
        .rdata(color_out)
    );
endmodule

// File: tb/tb_frame_buffer_dp.sv
// tb_frame_buffer_dp: directed self-checking bench for frame_buffer_dp
module tb_frame_buffer_dp;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, frame_start, line_start, pix_en, wr_valid, swap_req;
    logic wr_ready, swap_done, init_done;
    logic [5:0] wr_addr, wr_data, color_out;
    logic s_frame_start, s_line_start, s_pix_en, s_wr_valid, s_swap_req;
    logic s_wr_ready, s_swap_done, s_init_done;
    logic [2:0] s_wr_addr;
    logic [5:0] s_wr_data, s_color_out;
    int n_chk = 0;
    int n_fail = 0;
    logic [5:0] model [64];
    logic [5:0] disp [9][34];
    typedef struct { logic [5:0] addr; logic [5:0] data; bit keep; } wr_vec_t;
    typedef struct { int l; int p; logic [5:0] exp; } spot_t;
    typedef struct { logic fs; logic ls; logic pe; logic [5:0] exp; } s_vec_t;
    wr_vec_t wv [12];
    spot_t sp [14];
    s_vec_t sv [14];
    frame_buffer_dp #(.H_WIDTH(8), .V_WIDTH(4), .H_SCALE(4), .V_SCALE(2), .PAGES(2), .CLEAR_COLOR(9)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start), .pix_en(pix_en),
        .color_out(color_out), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_done(swap_done), .init_done(init_done)
    );
    frame_buffer_dp #(.H_WIDTH(3), .V_WIDTH(2), .H_SCALE(1), .V_SCALE(1), .PAGES(1), .CLEAR_COLOR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .line_start(s_line_start), .pix_en(s_pix_en),
        .color_out(s_color_out), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .swap_req(s_swap_req), .swap_done(s_swap_done), .init_done(s_init_done)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [5:0] a, input logic [5:0] d);
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check($sformatf("wr_ready a=%0d", a), wr_ready, 1);
        tick();
        wr_valid = 1'b0;
    endtask
    task automatic scan(input int page, input int rq_a, input int rq_b, input int rq_p, output int swaps);
        logic [5:0] last;
        swaps = 0;
        last = 6'h0;
        for (int l = 0; l < 9; l++) begin
            for (int p = 0; p < 34; p++) begin
                frame_start = l == 0 && p == 0;
                line_start = p == 0;
                pix_en = 1'b1;
                swap_req = (l == rq_a || l == rq_b) && p == rq_p;
                #1;
                if (swap_done) swaps++;
                tick();
                frame_start = 1'b0;
                line_start = 1'b0;
                swap_req = 1'b0;
                if (l < 8 && p < 32) last = model[page * 32 + (l / 2) * 8 + p / 4];
                disp[l][p] = color_out;
                check($sformatf("pix pg%0d l%0d p%0d", page, l, p), color_out, last);
            end
            pix_en = 1'b0;
            tick();
            check($sformatf("hold pg%0d l%0d", page, l), color_out, last);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, swaps, first_rdy;
        wv = '{'{6'd5, 6'h2A, 1'b1}, '{6'd8, 6'h15, 1'b1}, '{6'd9, 6'h15, 1'b1}, '{6'd10, 6'h15, 1'b1},
               '{6'd11, 6'h15, 1'b1}, '{6'd12, 6'h15, 1'b1}, '{6'd13, 6'h15, 1'b1}, '{6'd14, 6'h15, 1'b1},
               '{6'd15, 6'h15, 1'b1}, '{6'd31, 6'h07, 1'b1}, '{6'd0, 6'h33, 1'b1}, '{6'd40, 6'h3F, 1'b0}};
        sp = '{'{0, 0, 6'h33}, '{0, 3, 6'h33}, '{0, 4, 6'h09}, '{0, 19, 6'h09}, '{0, 20, 6'h2A},
               '{0, 23, 6'h2A}, '{0, 24, 6'h09}, '{1, 21, 6'h2A}, '{2, 0, 6'h15}, '{3, 31, 6'h15},
               '{4, 0, 6'h09}, '{7, 28, 6'h07}, '{7, 31, 6'h07}, '{8, 5, 6'h07}};
        sv = '{'{1'b1, 1'b1, 1'b1, 6'h3F}, '{1'b0, 1'b0, 1'b1, 6'h00}, '{1'b0, 1'b0, 1'b1, 6'h00},
               '{1'b0, 1'b0, 1'b1, 6'h00}, '{1'b0, 1'b0, 1'b0, 6'h00}, '{1'b0, 1'b1, 1'b1, 6'h00},
               '{1'b0, 1'b0, 1'b1, 6'h2B}, '{1'b0, 1'b0, 1'b1, 6'h1C}, '{1'b0, 1'b0, 1'b0, 6'h1C},
               '{1'b0, 1'b1, 1'b1, 6'h1C}, '{1'b0, 1'b0, 1'b1, 6'h1C}, '{1'b1, 1'b0, 1'b1, 6'h3F},
               '{1'b0, 1'b1, 1'b1, 6'h00}, '{1'b0, 1'b0, 1'b1, 6'h2B}};
        for (int i = 0; i < 64; i++) model[i] = 6'h09;
        s_frame_start = 1'b0; s_line_start = 1'b0; s_pix_en = 1'b0; s_wr_valid = 1'b0;
        s_swap_req = 1'b0; s_wr_addr = 3'd0; s_wr_data = 6'h0;
        wr_valid = 1'b0; wr_addr = 6'd0; wr_data = 6'h0;
        rst_n = 1'b0; frame_start = 1'b1; line_start = 1'b1; pix_en = 1'b1; swap_req = 1'b1;
        repeat (3) tick();
        check("rst color_out", color_out, 0);
        check("rst wr_ready", wr_ready, 0);
        check("rst init_done", init_done, 0);
        check("rst swap_done", swap_done, 0);
        check("rst s_init_done", s_init_done, 0);
        frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b0; swap_req = 1'b0;
        rst_n = 1'b1;
        repeat (40) tick();
        check("midclear init_done", init_done, 0);
        check("midclear wr_ready", wr_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        first_rdy = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
            if (wr_ready && first_rdy == 0) first_rdy = n;
        end
        check("init cycles", n, 64);
        check("first wr_ready cycle", first_rdy, 64);
        check("s_init_done", s_init_done, 1);
        check("post-clear color_out", color_out, 0);
        scan(0, -1, -1, -1, swaps);
        check("frame A swaps", swaps, 0);
        foreach (wv[i]) begin
            wr(wv[i].addr, wv[i].data);
            if (wv[i].keep) model[32 + int'(wv[i].addr)] = wv[i].data;
        end
        scan(0, 3, 5, 5, swaps);
        check("frame B swaps (pending only)", swaps, 0);
        scan(1, -1, -1, -1, swaps);
        check("frame C swaps", swaps, 1);
        foreach (sp[i]) check($sformatf("spot l%0d p%0d", sp[i].l, sp[i].p), disp[sp[i].l][sp[i].p], sp[i].exp);
        scan(1, -1, -1, -1, swaps);
        check("frame D swaps", swaps, 0);
        scan(0, 0, 0, 0, swaps);
        check("frame E swaps (req with frame_start)", swaps, 1);
        s_wr_valid = 1'b1; s_wr_addr = 3'd0; s_wr_data = 6'h3F;
        s_frame_start = 1'b1; s_line_start = 1'b1; s_pix_en = 1'b1;
        #1;
        check("s wr_ready rbw", s_wr_ready, 1);
        tick();
        check("s read-before-write", s_color_out, 0);
        s_wr_valid = 1'b0; s_frame_start = 1'b0; s_line_start = 1'b0; s_pix_en = 1'b0;
        tick();
        check("s hold after rbw", s_color_out, 0);
        s_wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_wr_addr = i == 0 ? 3'd4 : i == 1 ? 3'd5 : 3'd7;
            s_wr_data = i == 0 ? 6'h2B : i == 1 ? 6'h1C : 6'h11;
            #1;
            check($sformatf("s wr_ready a=%0d", s_wr_addr), s_wr_ready, 1);
            tick();
        end
        s_wr_valid = 1'b0;
        foreach (sv[i]) begin
            s_frame_start = sv[i].fs;
            s_line_start = sv[i].ls;
            s_pix_en = sv[i].pe;
            tick();
            check($sformatf("s vec %0d", i), s_color_out, sv[i].exp);
        end
        s_frame_start = 1'b0; s_line_start = 1'b0; s_pix_en = 1'b0;
        check("s swap_done", s_swap_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
